// File: rtl/opb_rst_reg_sequencer_if.sv
// OPB master-side signal bundle between the reset sequencer and the arbiter/register slave.
// Address and data buses keep the big-endian OPB bit numbering.
interface opb_rst_reg_sequencer_if;
    logic        M_request;
    logic        M_select;
    logic        M_RNW;
    logic        M_seqAddr;
    logic [0:31] M_ABus;
    logic [0:31] M_DBus;
    logic [0:3]  M_BE;
    logic        OPB_MGrant;
    logic        OPB_xferAck;
    logic        OPB_errAck;
    logic        OPB_retry;

    modport master (
        output M_request, M_select, M_RNW, M_seqAddr, M_ABus, M_DBus, M_BE,
        input  OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry
    );

    modport slave (
        input  M_request, M_select, M_RNW, M_seqAddr, M_ABus, M_DBus, M_BE,
        output OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry
    );
endinterface

// File: rtl/opb_rst_reg_sequencer.sv
// OPB write-only master that pulses the TGE core reset register: write ASSERT_VAL,
// wait HOLD_CYCLES, write DEASSERT_VAL, then report done or error.
module opb_rst_reg_sequencer #(
    parameter logic [31:0] C_BASEADDR   = 32'h01100800,
    parameter logic [31:0] ASSERT_VAL   = 32'h00000001,
    parameter logic [31:0] DEASSERT_VAL = 32'h00000000,
    parameter int unsigned HOLD_CYCLES  = 256,
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned MAX_RETRY    = 3,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic                           OPB_Clk,
    input  logic                           OPB_Rst_n,
    input  logic                           start,
    opb_rst_reg_sequencer_if.master        opb,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_HOLD, S_DONE, S_ERR} state_t;

    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);
    localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [3:0]  retry_q, retry_d;
    logic        boot_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        case (state_q)
            S_IDLE: begin
                // boot_q is low only on the first clock after reset release
                if (start || (AUTO_START && !boot_q)) begin
                    state_d = S_REQ;
                    phase_d = 1'b0;
                    retry_d = 4'd0;
                end
            end
            S_REQ: begin
                if (opb.OPB_MGrant) begin
                    state_d = S_XFER;
                    tmo_d   = 8'd0;
                end
            end
            S_XFER: begin
                if (opb.OPB_errAck) begin
                    state_d = S_ERR;
                end else if (opb.OPB_xferAck) begin
                    retry_d = 4'd0;
                    if (phase_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
                    end
                end else if (opb.OPB_retry) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ;
                        retry_d = retry_q + 4'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (hold_q == 16'd0) begin
                    state_d = S_REQ;
                    phase_d = 1'b1;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_REQ;
                    phase_d = 1'b0;
                    retry_d = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    logic sel_d;
    assign sel_d = (state_d == S_XFER);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 1'b0;
            hold_q        <= 16'd0;
            tmo_q         <= 8'd0;
            retry_q       <= 4'd0;
            boot_q        <= 1'b0;
            opb.M_request <= 1'b0;
            opb.M_select  <= 1'b0;
            opb.M_ABus    <= '0;
            opb.M_DBus    <= '0;
            opb.M_BE      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            tmo_q         <= tmo_d;
            retry_q       <= retry_d;
            boot_q        <= 1'b1;
            opb.M_request <= (state_d == S_REQ);
            opb.M_select  <= sel_d;
            opb.M_ABus    <= sel_d ? C_BASEADDR : 32'd0;
            opb.M_DBus    <= sel_d ? (phase_d ? DEASSERT_VAL : ASSERT_VAL) : 32'd0;
            opb.M_BE      <= sel_d ? 4'hF : 4'h0;
            busy          <= (state_d == S_REQ) || (state_d == S_XFER) || (state_d == S_HOLD);
            done          <= (state_d == S_DONE);
            error         <= (state_d == S_ERR);
        end
    end

    assign opb.M_RNW     = 1'b0;
    assign opb.M_seqAddr = 1'b0;

endmodule
